// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character LCD bus blocks.
// Reader state encoding, access modes and default bus timing.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EN_HI,
    S_EN_LO,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_BF   = 2'd0;
  localparam logic [1:0] MODE_DATA = 2'd1;
  localparam logic [1:0] MODE_POLL = 2'd2;

  localparam int T_SETUP_DEF   = 2;
  localparam int T_EN_HIGH_DEF = 25;
  localparam int T_EN_LOW_DEF  = 25;
  localparam int POLL_MAX_DEF  = 100;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter with a zero flag.
// Holds at zero until the next load.
module lcd_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Read-side HD44780 bus controller: single BF/AC or RAM reads
// and busy-flag polling with a bounded number of reads.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int T_SETUP   = T_SETUP_DEF,
  parameter int T_EN_HIGH = T_EN_HIGH_DEF,
  parameter int T_EN_LOW  = T_EN_LOW_DEF,
  parameter int POLL_MAX  = POLL_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [1:0] mode,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic       busy_flag,
  output logic [6:0] addr_cnt,
  output logic       timeout,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  input  logic [7:0] lcd_db_in
);

  localparam int TMAX = max3(T_SETUP, T_EN_HIGH, T_EN_LOW);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = $clog2(POLL_MAX + 1);

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_mode;
  logic [7:0]      r_rdata;
  logic            r_timeout;
  logic [PW-1:0]   r_poll;
  logic            w_load;
  logic [TW-1:0]   w_load_val;
  logic            w_zero;
  logic            w_accept;
  logic            w_sample;
  logic            w_poll_inc;
  logic            w_set_to;
  logic            w_bf_busy;

  lcd_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_zero  (w_zero)
  );

  assign w_accept  = (r_state == S_IDLE) && req;
  assign w_sample  = (r_state == S_EN_HI) && w_zero;
  assign w_bf_busy = (r_mode == MODE_POLL) && r_rdata[7];

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_poll_inc = 1'b0;
    w_set_to   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req) begin
          w_next     = S_SETUP;
          w_load     = 1'b1;
          w_load_val = TW'(T_SETUP - 1);
        end
      end
      S_SETUP: begin
        if (w_zero) begin
          w_next     = S_EN_HI;
          w_load     = 1'b1;
          w_load_val = TW'(T_EN_HIGH - 1);
        end
      end
      S_EN_HI: begin
        if (w_zero) begin
          w_next     = S_EN_LO;
          w_load     = 1'b1;
          w_load_val = TW'(T_EN_LOW - 1);
        end
      end
      S_EN_LO: begin
        if (w_zero) w_next = S_CHECK;
      end
      S_CHECK: begin
        // r_poll counts completed reads minus one
        if (w_bf_busy && (int'(r_poll) + 1 < POLL_MAX)) begin
          w_poll_inc = 1'b1;
          w_next     = S_SETUP;
          w_load     = 1'b1;
          w_load_val = TW'(T_SETUP - 1);
        end else begin
          w_set_to = w_bf_busy;
          w_next   = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mode    <= MODE_BF;
      r_rdata   <= 8'h00;
      r_timeout <= 1'b0;
      r_poll    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode    <= mode;
        r_poll    <= '0;
        r_timeout <= 1'b0;
      end
      if (w_sample) r_rdata <= lcd_db_in;
      if (w_poll_inc) r_poll <= r_poll + 1'b1;
      if (w_set_to) r_timeout <= 1'b1;
    end
  end

  // bus strobes decode straight from state so reset drops them at once
  assign lcd_rw = (r_state == S_SETUP) || (r_state == S_EN_HI) ||
                  (r_state == S_EN_LO) || (r_state == S_CHECK);
  assign lcd_en = (r_state == S_EN_HI);
  assign lcd_rs = lcd_rw && (r_mode == MODE_DATA);

  assign ready     = (r_state == S_IDLE);
  assign done      = (r_state == S_DONE);
  assign rdata     = r_rdata;
  assign busy_flag = r_rdata[7];
  assign addr_cnt  = r_rdata[6:0];
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Scoreboard bench for lcd_bus_reader: directed reads and polls,
// plus continuous checks on EN/RW/RS bus timing.
module tb_lcd_bus_reader;

  typedef struct {
    logic [7:0] rdata;
    logic       to;
    int         lat;
    int         pulses;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       ready;
  logic       done;
  logic [7:0] rdata;
  logic       busy_flag;
  logic [6:0] addr_cnt;
  logic       timeout;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_db_in = 8'h00;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   viol = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  int   rw_run = 0;
  int   aft = 0;
  bit   aft_arm = 0;
  bit   armed = 0;
  bit   prev_en = 0;
  bit   exp_rs = 0;

  lcd_bus_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mode      (mode),
    .ready     (ready),
    .done      (done),
    .rdata     (rdata),
    .busy_flag (busy_flag),
    .addr_cnt  (addr_cnt),
    .timeout   (timeout),
    .lcd_en    (lcd_en),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_db_in (lcd_db_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      armed   = 0;
      aft_arm = 0;
      prev_en = 0;
      rw_run  = 0;
    end else begin
      if (armed) cyc++;
      if (lcd_en && !prev_en) begin
        if (rw_run < 2) viol++;
        aft_arm = 0;
      end
      if (!lcd_en && prev_en) begin
        en_cnt++;
        aft_arm = 1;
        aft = 0;
      end
      if (aft_arm) begin
        if (lcd_rw) aft++;
        else begin
          if (aft < 25) viol++;
          aft_arm = 0;
        end
      end
      if (lcd_en && !lcd_rw) viol++;
      if (lcd_rw && (lcd_rs != exp_rs)) viol++;
      rw_run = lcd_rw ? rw_run + 1 : 0;
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("busy_flag", busy_flag, e.rdata[7]);
          chk("addr_cnt", addr_cnt, e.rdata[6:0]);
          chk("timeout", timeout, e.to);
          chk("latency", cyc, e.lat);
          chk("en_pulses", en_cnt, e.pulses);
          chk("rw_at_done", lcd_rw, 0);
        end
        armed = 0;
      end
      if (ready && req) begin
        armed  = 1;
        cyc    = 0;
        en_cnt = 0;
        exp_rs = (mode == 2'd1);
      end
      prev_en = lcd_en;
    end
  end

  task automatic issue(input logic [1:0] m);
    @(posedge clk); #1;
    mode = m;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    chk("timeout_cleared", timeout, 0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    for (i = 0; i < budget && q.size() != 0; i++) @(posedge clk);
    chk(name, q.size(), 0);
  endtask

  task automatic wait_en(input string name);
    for (int i = 0; i < 100 && !lcd_en; i++) @(posedge clk);
    #1;
    chk(name, lcd_en, 1);
  endtask

  task automatic single(input logic [1:0] m, input logic [7:0] db);
    exp_t e;
    lcd_db_in = db;
    e.rdata = db;
    e.to = 1'b0;
    e.lat = 54;
    e.pulses = 1;
    q.push_back(e);
    issue(m);
    wait_drain("single_drain", 200);
    @(posedge clk); #1;
    chk("ready_after", ready, 1);
    chk("rw_after", lcd_rw, 0);
  endtask

  initial begin
    exp_t e;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_en", lcd_en, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    single(2'd0, 8'h85);
    single(2'd1, 8'h41);
    single(2'd3, 8'h7F);

    lcd_db_in = 8'h80;
    e.rdata = 8'h12;
    e.to = 1'b0;
    e.lat = 4 * 53 + 1;
    e.pulses = 4;
    q.push_back(e);
    issue(2'd2);
    for (int i = 0; i < 400 && en_cnt < 3; i++) @(posedge clk);
    chk("poll_three_busy", en_cnt, 3);
    lcd_db_in = 8'h12;
    wait_drain("poll_drain", 400);

    lcd_db_in = 8'hFF;
    e.rdata = 8'hFF;
    e.to = 1'b1;
    e.lat = 100 * 53 + 1;
    e.pulses = 100;
    q.push_back(e);
    issue(2'd2);
    wait_drain("poll_to_drain", 6000);
    repeat (5) @(posedge clk);
    #1;
    chk("timeout_holds", timeout, 1);

    lcd_db_in = 8'h33;
    e.rdata = 8'h33;
    e.to = 1'b0;
    e.lat = 54;
    e.pulses = 1;
    q.push_back(e);
    issue(2'd0);
    wait_en("ign_en");
    mode = 2'd1;
    req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    req = 1'b0;
    mode = 2'd0;
    wait_drain("ign_drain", 200);
    repeat (70) @(posedge clk);
    #1;
    chk("ign_idle", ready, 1);

    lcd_db_in = 8'h5A;
    issue(2'd0);
    wait_en("rst_en_seen");
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_en", lcd_en, 0);
    chk("arst_rw", lcd_rw, 0);
    chk("arst_ready", ready, 1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    chk("post_rst_ready", ready, 1);
    chk("post_rst_rdata", rdata, 0);
    chk("post_rst_done", done, 0);

    single(2'd0, 8'h05);

    chk("bus_timing_viol", viol, 0);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
